key_switch_io: RTL and testbench
================================

# key_switch_io

Memory-mapped input device for the KEY[3:0] push-buttons and SW[9:0] slide switches. It sits on the processor's data bus beside data memory and the HEX/LEDR/LEDG output registers. It replaces the raw, combinational KEY/SW read path with synchronized, debounced data registers and sticky Ready/Overrun status. It also provides an interrupt request to the processor core. The memory-stage read mux takes `rdata` from this block whenever `sel` is high.

## Interface
Parameters:
- `DBITS`, 32, bus data/address width
- `ADDRKDATA`, 32'hF0000010, key data register (read-only)
- `ADDRSDATA`, 32'hF0000014, switch data register (read-only)
- `ADDRKCTRL`, 32'hF0000110, key control/status register
- `ADDRSCTRL`, 32'hF0000114, switch control/status register
- `DEBOUNCE`, 500000, number of cycles a synchronized SW value must be stable before it is accepted; must be at least 2

Ports:
- `clk`  in  1  system clock (PLL output)
- `reset`  in  1  asynchronous, active-high reset
- `KEY`  in  4  raw push-buttons, active-low, asynchronous to `clk`
- `SW`  in  10  raw switches, asynchronous to `clk`
- `addr`  in  DBITS  bus address
- `we`  in  1  bus write strobe
- `re`  in  1  bus read strobe; read side effects are committed at the clock edge
- `wdata`  in  DBITS  bus write data
- `sel`  out  1  `addr` matches one of the four registers
- `rdata`  out  DBITS  read data; combinational from `addr`; 0 when `sel`=0
- `irq`  out  1  registered interrupt request

## Operation
- Key path:
  - Two-flop synchronizer on ~KEY.
  - KDATA[3:0] loads the synchronized value on any edge where the two differ. Reads return {28'b0, KDATA}.
- Switch path:
  - Two-flop synchronizer on SW.
  - The synchronizer feeds the debouncer, which holds `cand` and a stability counter.
  - When the synchronized value differs from `cand`, the debouncer loads `cand` and clears the counter. Otherwise the counter increments and saturates.
  - When the counter reaches DEBOUNCE-1 and `cand` differs from SDATA, SDATA loads `cand`. Reads return {22'b0, SDATA}.
- Control registers (KCTRL and SCTRL share a layout):
  - bit0 Ready: read-only.
  - bit2 Overrun: write 0 to clear; writing 1 is ignored.
  - bit8 IE: read/write.
  - All other bits read as 0 and ignore writes.
- Ready and Overrun:
  - A DATA update sets Ready. If Ready is already 1 and DATA is not being read that cycle, Overrun is also set.
  - `re` on DATA clears Ready.
  - Writes to DATA addresses are ignored.
- Simultaneous events:
  - Update and DATA read in the same cycle: Ready=1, Overrun unchanged.
  - Update that would set Overrun and a write-0 to Overrun in the same cycle: Overrun=1 (set wins).
- `irq` is registered from (KIE & KReady) | (SIE & SReady).
- Reset values: KDATA=0, SDATA=0, synchronizers=0, `cand`=0, counter=0, all control bits=0, `irq`=0. Reset asserted mid-debounce discards the pending value.

## Timing
- Key latency: a raw change set up before edge 1 appears in KDATA, with Ready=1, after edge 3.
- Switch latency: a raw change before edge 1 loads `cand` at edge 3. SDATA and Ready update at edge 3+DEBOUNCE-1 if the input stays stable.
- A glitch shorter than DEBOUNCE cycles never reaches SDATA.
- Register writes and read side effects take effect at the edge where `we`/`re` is sampled.
- `rdata` returns pre-edge values, so a DATA read observes Ready=1 in CTRL one cycle earlier.
- `irq` follows the status bits by one cycle.

## Structure
- Shared package holds:
  - The four address constants.
  - Status bit positions READY=0, OVERRUN=2, IE=8.
- Sub-module `sw_debouncer`:
  - Parameters: width, DEBOUNCE.
  - Ports: clk, reset, din, dout, `upd` pulse.
  - The counter is $clog2(DEBOUNCE) bits wide.
- The top level instantiates `sw_debouncer` once for SW. KEY has no debouncer.

## Test plan
All tests use DEBOUNCE=4.
- Reset: assert `reset` asynchronously mid-cycle. KDATA, SDATA, KCTRL and SCTRL read 0, and `irq`=0. Pull KEY=4'b1110 → KDATA=1 and KCTRL=0x1 after 3 edges.
- Debounce: toggle SW=10'h155 for 2 cycles then back to 0 → SDATA stays 0. Hold SW at 10'h155 → SDATA=0x155, SCTRL=0x1 at edge 6.
- Overrun: two key changes with no read → KCTRL=0x5. Write KCTRL=0 → 0x1. Read KDATA → 0x0.
- Simultaneous events: a key update in the same cycle as a KDATA read → Ready stays 1 and Overrun stays 0. A new update coincident with a write-0 to Overrun → Overrun=1.
- Interrupt: write SCTRL=0x100, then make a switch change → `irq`=1 one cycle after Ready. Read SDATA → `irq`=0 one cycle later.
- Decode: reads of 0xF0000018 → `sel`=0 and `rdata`=0. Writes of 0xFFFFFFFF to KDATA and SCTRL → KDATA is unchanged and SCTRL reads 0x100.

Source files
------------

// File: rtl/key_switch_io_pkg.sv
// key_switch_io_pkg
// Shared definitions for the KEY/SW memory-mapped input device:
// register addresses, control/status bit positions, the control
// register record and its next-state and read-back helpers.
package key_switch_io_pkg;

   localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
   localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
   localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
   localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

   localparam int READY   = 0;
   localparam int OVERRUN = 2;
   localparam int IE      = 8;

   typedef struct packed {
      logic ready;
      logic overrun;
      logic ie;
   } ctrl_t;

   // Next control state. A set of Overrun takes priority over a write-0 clear,
   // and an update beats a DATA read so the new value is never lost.
   function automatic ctrl_t ctrl_next(ctrl_t cur, logic upd, logic rd,
                                       logic wr, logic w_ovr, logic w_ie);
      ctrl_t n;
      n = cur;
      if (upd && cur.ready && !rd) n.overrun = 1'b1;
      else if (wr && !w_ovr)       n.overrun = 1'b0;
      if (upd)     n.ready = 1'b1;
      else if (rd) n.ready = 1'b0;
      if (wr) n.ie = w_ie;
      return n;
   endfunction

   function automatic logic [31:0] ctrl_word(ctrl_t c);
      logic [31:0] w;
      w          = '0;
      w[READY]   = c.ready;
      w[OVERRUN] = c.overrun;
      w[IE]      = c.ie;
      return w;
   endfunction

endpackage

// File: rtl/key_switch_io_if.sv
// key_switch_io_if
// Processor data-bus slice seen by the KEY/SW device.
//   addr, wdata : address and write data from the core
//   we, re      : write and read strobes from the core
//   sel         : device claims the address
//   rdata       : combinational read data, 0 when not selected
interface key_switch_io_if #(
   parameter int DBITS = 32
);
   logic [DBITS-1:0] addr;
   logic [DBITS-1:0] wdata;
   logic [DBITS-1:0] rdata;
   logic             we;
   logic             re;
   logic             sel;

   modport master (output addr, we, re, wdata, input  sel, rdata);
   modport slave  (input  addr, we, re, wdata, output sel, rdata);
endinterface

// File: rtl/key_switch_io_sw_debouncer.sv
// sw_debouncer
// Accepts a synchronized multi-bit input only after it has been stable for
// DEBOUNCE cycles.
//   clk, reset : clock, asynchronous active-high reset
//   din        : synchronized input
//   dout       : accepted (debounced) value
//   upd        : high in the cycle whose edge loads dout with a new value
module sw_debouncer #(
   parameter int WIDTH    = 10,
   parameter int DEBOUNCE = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             upd
);
   localparam int             CW      = $clog2(DEBOUNCE);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

   logic [WIDTH-1:0] cand;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             stable;

   // The accept decision looks at the count being written this edge, so
   // dout moves on the same edge the counter reaches DEBOUNCE-1.
   always_comb begin
      stable  = (din == cand);
      cnt_nxt = '0;
      if (stable) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      upd     = stable && (cnt_nxt == CNT_MAX) && (cand != dout);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand <= '0;
         cnt  <= '0;
         dout <= '0;
      end else begin
         if (!stable) cand <= din;
         cnt <= cnt_nxt;
         if (upd) dout <= cand;
      end
   end
endmodule

// File: rtl/key_switch_io.sv
// key_switch_io
// Memory-mapped input device for KEY[3:0] and SW[9:0]: synchronized key
// data, synchronized and debounced switch data, sticky Ready/Overrun
// status, per-source interrupt enable and a registered interrupt request.
//   clk, reset : clock, asynchronous active-high reset
//   KEY        : raw active-low push-buttons (asynchronous)
//   SW         : raw slide switches (asynchronous)
//   bus        : data-bus slave port (addr/we/re/wdata in, sel/rdata out)
//   irq        : registered interrupt request
module key_switch_io
   import key_switch_io_pkg::*;
#(
   parameter int               DBITS     = 32,
   parameter logic [DBITS-1:0] ADDRKDATA = DBITS'(ADDR_KDATA),
   parameter logic [DBITS-1:0] ADDRSDATA = DBITS'(ADDR_SDATA),
   parameter logic [DBITS-1:0] ADDRKCTRL = DBITS'(ADDR_KCTRL),
   parameter logic [DBITS-1:0] ADDRSCTRL = DBITS'(ADDR_SCTRL),
   parameter int               DEBOUNCE  = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   key_switch_io_if.slave   bus,
   output logic             irq
);
   logic [3:0] k_s1, k_s2, kdata;
   logic [9:0] s_s1, s_s2, sdata;
   logic       k_upd, s_upd;
   logic       hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;
   ctrl_t      kctrl, sctrl;
   logic       unused_wdata;

   assign hit_kdata = (bus.addr == ADDRKDATA);
   assign hit_sdata = (bus.addr == ADDRSDATA);
   assign hit_kctrl = (bus.addr == ADDRKCTRL);
   assign hit_sctrl = (bus.addr == ADDRSCTRL);
   assign bus.sel   = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;

   // Only the Overrun and IE bits of wdata are meaningful.
   assign unused_wdata = ^bus.wdata;

   assign k_upd = (k_s2 != kdata);

   sw_debouncer #(.WIDTH(10), .DEBOUNCE(DEBOUNCE)) u_sw_deb (
      .clk   (clk),
      .reset (reset),
      .din   (s_s2),
      .dout  (sdata),
      .upd   (s_upd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_s1  <= '0;
         k_s2  <= '0;
         s_s1  <= '0;
         s_s2  <= '0;
         kdata <= '0;
         kctrl <= '0;
         sctrl <= '0;
         irq   <= 1'b0;
      end else begin
         k_s1  <= ~KEY;
         k_s2  <= k_s1;
         s_s1  <= SW;
         s_s2  <= s_s1;
         if (k_upd) kdata <= k_s2;
         kctrl <= ctrl_next(kctrl, k_upd, bus.re & hit_kdata, bus.we & hit_kctrl,
                            bus.wdata[OVERRUN], bus.wdata[IE]);
         sctrl <= ctrl_next(sctrl, s_upd, bus.re & hit_sdata, bus.we & hit_sctrl,
                            bus.wdata[OVERRUN], bus.wdata[IE]);
         irq   <= (kctrl.ie & kctrl.ready) | (sctrl.ie & sctrl.ready);
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (hit_kdata)      bus.rdata = DBITS'(kdata);
      else if (hit_sdata) bus.rdata = DBITS'(sdata);
      else if (hit_kctrl) bus.rdata = DBITS'(ctrl_word(kctrl));
      else if (hit_sctrl) bus.rdata = DBITS'(ctrl_word(sctrl));
   end
endmodule

// File: tb/tb_key_switch_io.sv
// tb_key_switch_io
// Directed bench for key_switch_io with DEBOUNCE=4. The driver issues one bus
// transaction per cycle and queues the expected read-back; a monitor on the
// falling edge pops and compares whenever a checked transaction is on the bus.
module tb_key_switch_io;
   import key_switch_io_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic       irq;

   key_switch_io_if #(.DBITS(32)) bus ();

   key_switch_io #(.DEBOUNCE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .KEY   (KEY),
      .SW    (SW),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sel;
      logic [31:0] data;
      logic        use_irq;
      logic        irq;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  e;
   string nm;
   int    n_cmp = 0;
   int    n_bad = 0;
   logic  look  = 1'b0;

   always @(negedge clk) begin
      if (look) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow: read on bus with nothing expected");
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if ({bus.sel, bus.rdata} !== {e.sel, e.data}) begin
               n_bad++;
               $display("FAIL %s: sel/rdata got %0b/%h want %0b/%h", nm, bus.sel, bus.rdata, e.sel, e.data);
            end
            if (e.use_irq) begin
               n_cmp++;
               if (irq !== e.irq) begin
                  n_bad++;
                  $display("FAIL %s_irq: irq got %0b want %0b", nm, irq, e.irq);
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.we = 1'b0;
      bus.re = 1'b0;
      look   = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic xact(input logic [31:0] a, input logic w, input logic r, input logic [31:0] wd,
                       input logic x_sel, input logic [31:0] x_data,
                       input logic x_use_irq, input logic x_irq, input string name);
      exp_t x;
      bus.addr  = a;
      bus.we    = w;
      bus.re    = r;
      bus.wdata = wd;
      x.sel     = x_sel;
      x.data    = x_data;
      x.use_irq = x_use_irq;
      x.irq     = x_irq;
      exp_q.push_back(x);
      name_q.push_back(name);
      look = 1'b1;
      cyc();
   endtask

   task automatic peek(input logic [31:0] a, input logic [31:0] d, input string name);
      xact(a, 1'b0, 1'b0, 32'h0, 1'b1, d, 1'b0, 1'b0, name);
   endtask

   task automatic peek_irq(input logic [31:0] a, input logic [31:0] d, input logic i, input string name);
      xact(a, 1'b0, 1'b0, 32'h0, 1'b1, d, 1'b1, i, name);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d, input string name);
      xact(a, 1'b0, 1'b1, 32'h0, 1'b1, d, 1'b0, 1'b0, name);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd);
      bus.addr  = a;
      bus.we    = 1'b1;
      bus.re    = 1'b0;
      bus.wdata = wd;
      look      = 1'b0;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      KEY       = 4'hF;
      SW        = 10'h0;
      bus.addr  = 32'h0;
      bus.we    = 1'b0;
      bus.re    = 1'b0;
      bus.wdata = 32'h0;
      repeat (2) cyc();
      reset = 1'b0;
      idle(2);

      // Build up non-zero state, then reset asynchronously mid-debounce.
      KEY = 4'b0111;
      SW  = 10'h3FF;
      wr(ADDR_KCTRL, 32'h100);
      idle(3);
      peek_irq(ADDR_KCTRL, 32'h101, 1'b1, "pre_reset_kctrl");
      #3;
      reset = 1'b1;
      KEY   = 4'hF;
      SW    = 10'h0;
      peek_irq(ADDR_KCTRL, 32'h0, 1'b0, "async_reset_kctrl");
      peek(ADDR_KDATA, 32'h0, "reset_kdata");
      peek(ADDR_SDATA, 32'h0, "reset_sdata");
      peek_irq(ADDR_SCTRL, 32'h0, 1'b0, "reset_sctrl");
      reset = 1'b0;
      idle(6);
      peek(ADDR_SDATA, 32'h0, "reset_discard_sdata");

      // Key latency: visible after the third edge, not before.
      KEY = 4'b1110;
      idle(2);
      peek(ADDR_KCTRL, 32'h0, "key_lat_edge2");
      peek(ADDR_KCTRL, 32'h1, "key_lat_edge3");
      peek_irq(ADDR_KDATA, 32'h1, 1'b0, "key_data_1");

      // Overrun, clear by write-0, clear Ready by read.
      KEY = 4'b1100;
      idle(3);
      peek(ADDR_KCTRL, 32'h5, "overrun_set");
      peek(ADDR_KDATA, 32'h3, "key_data_3");
      wr(ADDR_KCTRL, 32'h0);
      peek(ADDR_KCTRL, 32'h1, "overrun_clear");
      rd(ADDR_KDATA, 32'h3, "kdata_read");
      peek(ADDR_KCTRL, 32'h0, "ready_clear");

      // Update coincident with DATA read while Ready=1.
      KEY = 4'b1000;
      idle(3);
      peek(ADDR_KCTRL, 32'h1, "coinc_setup");
      KEY = 4'b0000;
      idle(2);
      rd(ADDR_KDATA, 32'h7, "coinc_read");
      peek(ADDR_KCTRL, 32'h1, "coinc_ready_no_ovr");
      peek(ADDR_KDATA, 32'hF, "coinc_new_data");

      // Overrun set coincident with write-0 to Overrun.
      KEY = 4'b1111;
      idle(2);
      wr(ADDR_KCTRL, 32'h0);
      peek(ADDR_KCTRL, 32'h5, "ovr_set_wins");
      wr(ADDR_KCTRL, 32'h0);
      rd(ADDR_KDATA, 32'h0, "cleanup_read");
      peek(ADDR_KCTRL, 32'h0, "cleanup_kctrl");

      // Switch glitch shorter than DEBOUNCE.
      SW = 10'h155;
      idle(2);
      SW = 10'h0;
      idle(8);
      peek(ADDR_SDATA, 32'h0, "glitch_sdata");
      peek(ADDR_SCTRL, 32'h0, "glitch_sctrl");

      // Stable switch value accepted at edge 6.
      SW = 10'h155;
      idle(5);
      peek(ADDR_SCTRL, 32'h0, "deb_edge5");
      peek(ADDR_SCTRL, 32'h1, "deb_edge6");
      rd(ADDR_SDATA, 32'h155, "deb_sdata");
      peek(ADDR_SCTRL, 32'h0, "deb_ready_clear");

      // Interrupt follows status by one cycle.
      SW = 10'h2AA;
      wr(ADDR_SCTRL, 32'h100);
      idle(5);
      peek_irq(ADDR_SCTRL, 32'h101, 1'b0, "irq_lag");
      xact(ADDR_SDATA, 1'b0, 1'b1, 32'h0, 1'b1, 32'h2AA, 1'b1, 1'b1, "irq_read_sdata");
      peek_irq(ADDR_SCTRL, 32'h100, 1'b1, "irq_hold");
      peek_irq(ADDR_SCTRL, 32'h100, 1'b0, "irq_drop");

      // Decode hole and writes to read-only / reserved bits.
      xact(32'hF000_0018, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "decode_hole");
      wr(ADDR_KDATA, 32'hFFFF_FFFF);
      peek(ADDR_KDATA, 32'h0, "kdata_write_ignored");
      wr(ADDR_SCTRL, 32'hFFFF_FFFF);
      peek(ADDR_SCTRL, 32'h100, "sctrl_write_mask");

      idle(2);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
